axi_ram_slave_128bit: RTL and testbench



---
 rtl/axi_ram_slave_128bit_if.sv | 71 +++++++
 rtl/axi_ram_slave_128bit.sv | 204 ++++++++++++++++++++
 tb/tb_axi_ram_slave_128bit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_slave_128bit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_ram_slave_128bit_if : AXI3/4 bus bundle for the RAM-backed slave.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface axi_ram_slave_128bit_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     axi_awid;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic [7:0]              axi_awlen;
  logic [2:0]              axi_awsize;
  logic [1:0]              axi_awburst;
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_wlast;
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [ID_WIDTH-1:0]     axi_bid;
  logic [1:0]              axi_bresp;
  logic                    axi_bvalid;
  logic                    axi_bready;
  logic [ID_WIDTH-1:0]     axi_arid;
  logic [ADDR_WIDTH-1:0]   axi_araddr;
  logic [7:0]              axi_arlen;
  logic [2:0]              axi_arsize;
  logic [1:0]              axi_arburst;
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [ID_WIDTH-1:0]     axi_rid;
  logic [DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]              axi_rresp;
  logic                    axi_rlast;
  logic                    axi_rvalid;
  logic                    axi_rready;
  logic                    proto_err;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    output proto_err
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    input  proto_err
  );
endinterface
`default_nettype wire

// File: rtl/axi_ram_slave_128bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_ram_slave_128bit : AXI INCR-burst slave backed by on-chip RAM, with  |
// | independent write/read engines (one outstanding burst each).  Rev 1.0   |
// +--------------------------------------------------------------------------+
module axi_ram_slave_128bit #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_AW     = 10
) (
  input  logic                   axi_clk,
  input  logic                   top_rst_n,
  axi_ram_slave_128bit_if.slave  bus
);
  localparam int NB       = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam logic [RAM_AW-1:0] IDX_ONE = RAM_AW'(1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_e;

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<RAM_AW)-1];

  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
  logic [RAM_AW-1:0]     wr_idx_q, wr_idx_d;
  logic [7:0]            wr_len_q, wr_len_d;
  logic [7:0]            wr_beat_q, wr_beat_d;
  logic                  wr_err_q, wr_err_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  proto_err_q, proto_err_d;
  logic                  ram_we;
  logic                  wr_final;
  logic                  wr_mismatch;

  rd_state_e             rd_state_q, rd_state_d;
  logic [RAM_AW-1:0]     rd_idx_q, rd_idx_d;
  logic [7:0]            rd_len_q, rd_len_d;
  logic [7:0]            rd_beat_q, rd_beat_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rlast_q, rlast_d;

  // Burst length comes from awlen alone; wlast is only checked, never obeyed.
  assign wr_final    = (wr_beat_q == wr_len_q);
  assign wr_mismatch = (bus.axi_wlast != wr_final);

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_id_d     = wr_id_q;
    wr_idx_d    = wr_idx_q;
    wr_len_d    = wr_len_q;
    wr_beat_d   = wr_beat_q;
    wr_err_d    = wr_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    proto_err_d = proto_err_q;
    ram_we      = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (bus.axi_awvalid) begin
          wr_id_d    = bus.axi_awid;
          wr_idx_d   = bus.axi_awaddr[ADDR_LSB +: RAM_AW];
          wr_len_d   = bus.axi_awlen;
          wr_beat_d  = 8'd0;
          wr_err_d   = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.axi_wvalid) begin
          ram_we    = 1'b1;
          wr_idx_d  = wr_idx_q + IDX_ONE;
          wr_beat_d = wr_beat_q + 8'd1;
          if (wr_mismatch) begin
            wr_err_d    = 1'b1;
            proto_err_d = 1'b1;
          end
          if (wr_final) begin
            bid_d      = wr_id_q;
            bresp_d    = (wr_err_q || wr_mismatch) ? 2'b10 : 2'b00;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.axi_bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_beat_d  = rd_beat_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    case (rd_state_q)
      R_IDLE: begin
        if (bus.axi_arvalid) begin
          rid_d      = bus.axi_arid;
          rd_idx_d   = bus.axi_araddr[ADDR_LSB +: RAM_AW];
          rd_len_d   = bus.axi_arlen;
          rd_beat_d  = 8'd0;
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        // Same-edge write to this word is not yet visible: old data is returned.
        rdata_d    = mem_q[rd_idx_q];
        rlast_d    = (rd_beat_q == rd_len_q);
        rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (bus.axi_rready) begin
          if (rlast_q) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_idx_d   = rd_idx_q + IDX_ONE;
            rd_beat_d  = rd_beat_q + 8'd1;
            rd_state_d = R_FETCH;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      wr_state_q  <= W_IDLE;
      wr_id_q     <= '0;
      wr_idx_q    <= '0;
      wr_len_q    <= '0;
      wr_beat_q   <= '0;
      wr_err_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      proto_err_q <= 1'b0;
      rd_state_q  <= R_IDLE;
      rd_idx_q    <= '0;
      rd_len_q    <= '0;
      rd_beat_q   <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rlast_q     <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_id_q     <= wr_id_d;
      wr_idx_q    <= wr_idx_d;
      wr_len_q    <= wr_len_d;
      wr_beat_q   <= wr_beat_d;
      wr_err_q    <= wr_err_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      proto_err_q <= proto_err_d;
      rd_state_q  <= rd_state_d;
      rd_idx_q    <= rd_idx_d;
      rd_len_q    <= rd_len_d;
      rd_beat_q   <= rd_beat_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rlast_q     <= rlast_d;
    end
  end

  // RAM array is deliberately outside the reset domain.
  always_ff @(posedge axi_clk) begin
    if (ram_we) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.axi_wstrb[i]) begin
          mem_q[wr_idx_q][8*i +: 8] <= bus.axi_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.axi_awready = (wr_state_q == W_IDLE);
  assign bus.axi_wready  = (wr_state_q == W_DATA);
  assign bus.axi_bvalid  = (wr_state_q == W_RESP);
  assign bus.axi_bid     = bid_q;
  assign bus.axi_bresp   = bresp_q;
  assign bus.proto_err   = proto_err_q;

  assign bus.axi_arready = (rd_state_q == R_IDLE);
  assign bus.axi_rvalid  = (rd_state_q == R_DATA);
  assign bus.axi_rid     = rid_q;
  assign bus.axi_rdata   = rdata_q;
  assign bus.axi_rlast   = rlast_q;
  assign bus.axi_rresp   = 2'b00;

  logic unused_ok;
  assign unused_ok = ^{bus.axi_awsize, bus.axi_awburst, bus.axi_arsize, bus.axi_arburst,
                       bus.axi_awaddr[ADDR_WIDTH-1:0], bus.axi_araddr[ADDR_WIDTH-1:0]};
endmodule
`default_nettype wire

// File: tb/tb_axi_ram_slave_128bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_ram_slave_128bit : directed bench for the AXI RAM slave.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axi_ram_slave_128bit;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_ram_slave_128bit_if #(.DATA_WIDTH(128), .ID_WIDTH(8), .ADDR_WIDTH(32)) bus ();

  axi_ram_slave_128bit #(
    .DATA_WIDTH(128), .ID_WIDTH(8), .ADDR_WIDTH(32), .RAM_AW(10)
  ) dut (
    .axi_clk   (clk),
    .top_rst_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [7:0]   id;
    logic [127:0] wdata;
    logic [15:0]  strb;
    logic [127:0] exp_rdata;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] wbuf   [256];
  logic [127:0] rbuf   [256];
  logic         rlbuf  [256];
  logic [7:0]   ridbuf [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles", name, TMO);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input int len,
                          input logic [15:0] strb, input int wlast_at,
                          output logic [7:0] bid_o, output logic [1:0] bresp_o);
    int t;
    bus.axi_awaddr  = addr;
    bus.axi_awid    = id;
    bus.axi_awlen   = len[7:0];
    bus.axi_awsize  = 3'd4;
    bus.axi_awburst = 2'b01;
    bus.axi_awvalid = 1'b1;
    t = 0;
    while (!bus.axi_awready && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) tmo("aw_handshake");
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.axi_wdata  = wbuf[b];
      bus.axi_wstrb  = strb;
      bus.axi_wlast  = (b == wlast_at);
      bus.axi_wvalid = 1'b1;
      t = 0;
      while (!bus.axi_wready && t < TMO) begin @(posedge clk); #1; t++; end
      if (t >= TMO) tmo("w_handshake");
      @(posedge clk); #1;
    end
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
    bus.axi_bready = 1'b1;
    t = 0;
    while (!bus.axi_bvalid && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) tmo("b_handshake");
    bid_o   = bus.axi_bid;
    bresp_o = bus.axi_bresp;
    @(posedge clk); #1;
    bus.axi_bready = 1'b0;
  endtask

  // lat: cycles from AR handshake cycle to first rvalid; last_cyc: cycle of final accept.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input int len,
                         input bit rand_rr, output int lat, output int last_cyc);
    int t, b, cyc;
    bit first, held, rr;
    logic [127:0] held_data;
    lat = -1; last_cyc = -1;
    bus.axi_araddr  = addr;
    bus.axi_arid    = id;
    bus.axi_arlen   = len[7:0];
    bus.axi_arsize  = 3'd4;
    bus.axi_arburst = 2'b01;
    bus.axi_arvalid = 1'b1;
    t = 0;
    while (!bus.axi_arready && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) tmo("ar_handshake");
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b0;
    b = 0; cyc = 1; first = 1'b1; held = 1'b0; held_data = '0;
    while (b <= len && cyc < TMO * 4) begin
      rr = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.axi_rready = rr;
      if (bus.axi_rvalid) begin
        if (first) begin lat = cyc; first = 1'b0; end
        if (held) chk("rdata_stable_in_stall", bus.axi_rdata, held_data);
        if (rr) begin
          rbuf[b]   = bus.axi_rdata;
          rlbuf[b]  = bus.axi_rlast;
          ridbuf[b] = bus.axi_rid;
          last_cyc  = cyc;
          held      = 1'b0;
          b++;
        end else begin
          held      = 1'b1;
          held_data = bus.axi_rdata;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.axi_rready = 1'b0;
    if (b <= len) tmo("r_beats");
  endtask

  vec_t       vecs [5];
  logic [7:0] bid;
  logic [1:0] bresp;
  int         lat, last_cyc, t, nb;

  initial begin
    vecs[0] = '{32'h20, 8'h05, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF,
                128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[1] = '{32'h40, 8'h11, {128{1'b1}}, 16'hFFFF, {128{1'b1}}};
    vecs[2] = '{32'h40, 8'h12, 128'h0, 16'h00FF, {{64{1'b1}}, 64'h0}};
    vecs[3] = '{32'h40, 8'h13, {16{8'hAA}}, 16'h8001, 128'hAAFFFFFFFFFFFFFF00000000000000AA};
    vecs[4] = '{32'h20, 8'h77, 128'h11111111222222223333333344444444, 16'hF0F0,
                128'h1111111189ABCDEF3333333389ABCDEF};

    bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awsize = '0;
    bus.axi_awburst = '0; bus.axi_awvalid = 1'b0; bus.axi_wdata = '0; bus.axi_wstrb = '0;
    bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_bready = 1'b0;
    bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arsize = '0;
    bus.axi_arburst = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_awready", 128'(bus.axi_awready), 128'd1);
    chk("rst_arready", 128'(bus.axi_arready), 128'd1);
    chk("rst_wready",  128'(bus.axi_wready),  128'd0);
    chk("rst_bvalid",  128'(bus.axi_bvalid),  128'd0);
    chk("rst_rvalid",  128'(bus.axi_rvalid),  128'd0);
    chk("rst_rlast",   128'(bus.axi_rlast),   128'd0);
    chk("rst_proto",   128'(bus.proto_err),   128'd0);
    chk("rst_bid_rid", {bus.axi_bid, bus.axi_rid, bus.axi_bresp, bus.axi_rresp}, 128'd0);
    chk("rst_rdata",   bus.axi_rdata, 128'd0);

    for (int i = 0; i < 5; i++) begin
      wbuf[0] = vecs[i].wdata;
      do_write(vecs[i].addr, vecs[i].id, 0, vecs[i].strb, 0, bid, bresp);
      chk($sformatf("vec%0d_bid", i), 128'(bid), 128'(vecs[i].id));
      chk($sformatf("vec%0d_bresp", i), 128'(bresp), 128'd0);
      do_read(vecs[i].addr, vecs[i].id, 0, 1'b0, lat, last_cyc);
      chk($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp_rdata);
      chk($sformatf("vec%0d_rid", i), 128'(ridbuf[0]), 128'(vecs[i].id));
      chk($sformatf("vec%0d_rlast", i), 128'(rlbuf[0]), 128'd1);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd2);
    end

    // 16-beat INCR with random read back-pressure
    for (int b = 0; b < 16; b++) wbuf[b] = 128'(b);
    do_write(32'h100, 8'h21, 15, 16'hFFFF, 15, bid, bresp);
    chk("b16_bresp", 128'(bresp), 128'd0);
    chk("b16_bid", 128'(bid), 128'h21);
    do_read(32'h100, 8'h22, 15, 1'b1, lat, last_cyc);
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("b16_data%0d", b), rbuf[b], 128'(b));
      chk($sformatf("b16_rlast%0d", b), 128'(rlbuf[b]), 128'(b == 15));
      chk($sformatf("b16_rid%0d", b), 128'(ridbuf[b]), 128'h22);
    end
    chk("b16_proto_err", 128'(bus.proto_err), 128'd0);

    // Index wrap at the top of the RAM, and upper-address aliasing
    wbuf[0] = {16{8'hA5}};
    wbuf[1] = {16{8'h5A}};
    do_write(32'h3FF0, 8'h31, 1, 16'hFFFF, 1, bid, bresp);
    chk("wrap_bresp", 128'(bresp), 128'd0);
    do_read(32'h0, 8'h32, 0, 1'b0, lat, last_cyc);
    chk("wrap_word0", rbuf[0], {16{8'h5A}});
    do_read(32'h3FF0, 8'h33, 1, 1'b0, lat, last_cyc);
    chk("wrap_rd_beat0", rbuf[0], {16{8'hA5}});
    chk("wrap_rd_beat1", rbuf[1], {16{8'h5A}});
    chk("wrap_rd_rlast0", 128'(rlbuf[0]), 128'd0);
    chk("rd_two_cycle_beats", 128'(last_cyc), 128'd4);
    do_read(32'h4000, 8'h34, 0, 1'b0, lat, last_cyc);
    chk("alias_word0", rbuf[0], {16{8'h5A}});

    // Early wlast: burst still runs all 4 beats, SLVERR and sticky proto_err
    for (int b = 0; b < 4; b++) wbuf[b] = 128'h1000 + 128'(b);
    do_write(32'h200, 8'h41, 3, 16'hFFFF, 1, bid, bresp);
    chk("mis_bresp", 128'(bresp), 128'h2);
    chk("mis_bid", 128'(bid), 128'h41);
    chk("mis_proto_err", 128'(bus.proto_err), 128'd1);
    do_read(32'h200, 8'h42, 3, 1'b0, lat, last_cyc);
    for (int b = 0; b < 4; b++)
      chk($sformatf("mis_data%0d", b), rbuf[b], 128'h1000 + 128'(b));
    chk("mis_proto_sticky", 128'(bus.proto_err), 128'd1);

    // Reset in the middle of an 8-beat read
    bus.axi_araddr = 32'h100; bus.axi_arid = 8'h51; bus.axi_arlen = 8'd7;
    bus.axi_arvalid = 1'b1;
    t = 0;
    while (!bus.axi_arready && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) tmo("rst_ar_handshake");
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b0;
    bus.axi_rready  = 1'b1;
    nb = 0; t = 0;
    while (nb < 2 && t < TMO) begin
      if (bus.axi_rvalid) nb++;
      @(posedge clk); #1; t++;
    end
    if (nb < 2) tmo("rst_first_beats");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 128'(bus.axi_rvalid), 128'd0);
    chk("rst_mid_arready", 128'(bus.axi_arready), 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.axi_rready = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rvalid", 128'(bus.axi_rvalid), 128'd0);
    chk("post_rst_arready", 128'(bus.axi_arready), 128'd1);
    chk("post_rst_awready", 128'(bus.axi_awready), 128'd1);
    chk("post_rst_proto_err", 128'(bus.proto_err), 128'd0);
    do_read(32'h100, 8'h52, 15, 1'b0, lat, last_cyc);
    for (int b = 0; b < 16; b++)
      chk($sformatf("post_rst_data%0d", b), rbuf[b], 128'(b));
    chk("post_rst_rate", 128'(last_cyc), 128'd32);

    // Concurrent write and read bursts on disjoint words
    for (int b = 0; b < 8; b++) wbuf[b] = {4{32'(32'hC0DE0000 + 32'(b))}};
    fork
      do_write(32'h800, 8'h61, 7, 16'hFFFF, 7, bid, bresp);
      do_read(32'h100, 8'h62, 15, 1'b1, lat, last_cyc);
    join
    chk("conc_bresp", 128'(bresp), 128'd0);
    chk("conc_bid", 128'(bid), 128'h61);
    for (int b = 0; b < 16; b++)
      chk($sformatf("conc_rd_data%0d", b), rbuf[b], 128'(b));
    do_read(32'h800, 8'h63, 7, 1'b0, lat, last_cyc);
    for (int b = 0; b < 8; b++)
      chk($sformatf("conc_wr_data%0d", b), rbuf[b], {4{32'(32'hC0DE0000 + 32'(b))}});
    chk("conc_proto_err", 128'(bus.proto_err), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
`default_nettype wire
